// File: rtl/fixed_bias_add_join.sv
// Joins an activation beat with a bias beat, adds the broadcast bias in fixed point,
// and presents the result through a main + skid output register pair.
module fixed_bias_add_join #(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PRECISION_1       = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 16,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int TENSOR_SIZE_DIM_0      = 32,
    parameter int PARALLELISM_DIM_0      = 1,
    parameter int PARALLELISM_DIM_1      = 1,
    parameter int DEPTH                  = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    input  logic [BIAS_PRECISION_0-1:0]       bias [PARALLELISM_DIM_0],
    input  logic                              bias_valid,
    output logic                              bias_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last
);

    localparam int N     = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int DW    = DATA_IN_0_PRECISION_0;
    localparam int BW    = BIAS_PRECISION_0;
    localparam int OW    = DATA_OUT_0_PRECISION_0;
    localparam int SHB   = DATA_IN_0_PRECISION_1 - BIAS_PRECISION_1;
    localparam int SHO   = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    localparam int AW    = (DW > BW + SHB) ? DW : BW + SHB;
    localparam int SW    = AW + 1;
    localparam int CW    = ((SW > OW) ? SW : OW) + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    generate
        if (DATA_IN_0_PRECISION_1 < BIAS_PRECISION_1) begin : g_err_bias_frac
            $error("bias fraction bits exceed data fraction bits");
        end
        if (DATA_OUT_0_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_err_out_frac
            $error("output fraction bits exceed data fraction bits");
        end
        if (TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0 != 0) begin : g_err_depth
            $error("TENSOR_SIZE_DIM_0 not divisible by PARALLELISM_DIM_0");
        end
    endgenerate

    // Align bias to the data binary point, add one bit wider, floor-shift, then saturate.
    function automatic logic [OW-1:0] add_one(input logic [DW-1:0] d, input logic [BW-1:0] b);
        logic signed [SW-1:0] d_ext;
        logic signed [SW-1:0] b_ext;
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] shr;
        logic signed [CW-1:0] wide;
        d_ext = {{(SW-DW){d[DW-1]}}, d};
        b_ext = {{(SW-BW){b[BW-1]}}, b} <<< SHB;
        sum   = d_ext + b_ext;
        shr   = sum >>> SHO;
        wide  = {{(CW-SW){shr[SW-1]}}, shr};
        if (wide > SAT_MAX)      add_one = SAT_MAX[OW-1:0];
        else if (wide < SAT_MIN) add_one = SAT_MIN[OW-1:0];
        else                     add_one = wide[OW-1:0];
    endfunction

    logic [OW-1:0]    w_result [N];
    logic             w_ready;
    logic             w_fire;
    logic             w_drain;
    logic             w_last;

    logic [OW-1:0]    r_main_data [N];
    logic             r_main_valid;
    logic             r_main_last;
    logic [OW-1:0]    r_skid_data [N];
    logic             r_skid_valid;
    logic             r_skid_last;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_result = '{default: '0};
        for (int i = 0; i < PARALLELISM_DIM_1; i++) begin
            for (int j = 0; j < PARALLELISM_DIM_0; j++) begin
                w_result[i*PARALLELISM_DIM_0+j] = add_one(data_in_0[i*PARALLELISM_DIM_0+j], bias[j]);
            end
        end
    end

    assign w_ready = ~r_skid_valid;
    assign w_fire  = data_in_0_valid & bias_valid & w_ready & ~rst;
    assign w_drain = r_main_valid & data_out_0_ready;
    assign w_last  = (r_cnt == CNT_W'(DEPTH - 1));

    // NOTE: non-blocking assignments let skid->main and new->skid moves read pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data  <= '{default: '0};
            r_main_valid <= 1'b0;
            r_main_last  <= 1'b0;
            r_skid_data  <= '{default: '0};
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_fire) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            // A fire implies skid is empty, so skid never needs to move on a fire edge.
            if (w_fire && (!r_main_valid || w_drain)) begin
                r_main_data  <= w_result;
                r_main_last  <= w_last;
                r_main_valid <= 1'b1;
            end else if (w_fire) begin
                r_skid_data  <= w_result;
                r_skid_last  <= w_last;
                r_skid_valid <= 1'b1;
            end else if (w_drain && r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_last  <= r_skid_last;
                r_skid_valid <= 1'b0;
            end else if (w_drain) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign data_in_0_ready  = w_ready;
    assign bias_ready       = w_ready;
    assign data_out_0       = r_main_data;
    assign data_out_0_valid = r_main_valid;
    assign data_out_0_last  = r_main_last;

endmodule

// File: tb/tb_fixed_bias_add_join.sv
// Directed bench for fixed_bias_add_join: reset, arithmetic, saturation, wrap,
// backpressure ordering and a finer-input-precision instance.
module tb_fixed_bias_add_join;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in_0 [1];
    logic        data_in_0_valid;
    logic        data_in_0_ready;
    logic [15:0] bias [1];
    logic        bias_valid;
    logic        bias_ready;
    logic [15:0] data_out_0 [1];
    logic        data_out_0_valid;
    logic        data_out_0_ready;
    logic        data_out_0_last;

    logic        p_data_in_0_ready;
    logic        p_bias_ready;
    logic [15:0] p_data_out_0 [1];
    logic        p_data_out_0_valid;
    logic        p_data_out_0_last;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fixed_bias_add_join u_dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .bias             (bias),
        .bias_valid       (bias_valid),
        .bias_ready       (bias_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .data_out_0_last  (data_out_0_last)
    );

    fixed_bias_add_join #(.DATA_IN_0_PRECISION_1(5)) u_dut_p (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (p_data_in_0_ready),
        .bias             (bias),
        .bias_valid       (bias_valid),
        .bias_ready       (p_bias_ready),
        .data_out_0       (p_data_out_0),
        .data_out_0_valid (p_data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .data_out_0_last  (p_data_out_0_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [15:0] b, input logic v);
        data_in_0[0]    = d;
        bias[0]         = b;
        data_in_0_valid = v;
        bias_valid      = v;
    endtask

    // Two reset edges with both valids held high; output must stay invalid throughout.
    task automatic do_reset();
        rst = 1'b1;
        drive(16'h1234, 16'h0001, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_valid", data_out_0_valid, 1'b0);
            check("rst_last", data_out_0_last, 1'b0);
        end
        rst = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0);
        check("rst_ready", data_in_0_ready, 1'b1);
        step();
        check("post_rst_valid", data_out_0_valid, 1'b0);
    endtask

    task automatic one_beat(input string tag, input logic [15:0] d, input logic [15:0] b,
                            input logic [15:0] exp);
        drive(d, b, 1'b1);
        step();
        check({tag, "_valid"}, data_out_0_valid, 1'b1);
        check(tag, data_out_0[0], exp);
        drive(16'h0000, 16'h0000, 1'b0);
        step();
        check({tag, "_drain"}, data_out_0_valid, 1'b0);
    endtask

    logic [15:0] bp_d   [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    logic [15:0] bp_b   [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] bp_exp [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    logic [15:0] got_q  [$];
    logic        last_q [$];

    initial begin
        data_out_0_ready = 1'b1;
        do_reset();

        one_beat("basic", 16'h0010, 16'h0008, 16'h0018);
        one_beat("sat_pos", 16'h7FF0, 16'h0020, 16'h7FFF);
        one_beat("sat_neg", 16'h8000, 16'hFFF8, 16'h8000);
        one_beat("neg_sum", 16'hFFF0, 16'h0008, 16'hFFF8);

        // Fill main and skid, then reset: buffered beats must be discarded.
        data_out_0_ready = 1'b0;
        drive(16'h0055, 16'h0001, 1'b1);
        step();
        step();
        check("fill_ready_low", data_in_0_ready, 1'b0);
        data_out_0_ready = 1'b1;
        do_reset();

        // 33 consecutive fires: last only on beat 31, counter wraps to 0 for beat 32.
        for (int k = 0; k < 33; k++) begin
            drive(16'(k), 16'h0000, 1'b1);
            step();
            check("wrap_valid", data_out_0_valid, 1'b1);
            check("wrap_data", data_out_0[0], 16'(k));
            check($sformatf("wrap_last_%0d", k), data_out_0_last, (k == 31) ? 1'b1 : 1'b0);
        end
        drive(16'h0000, 16'h0000, 1'b0);
        step();
        check("wrap_drain", data_out_0_valid, 1'b0);

        // Backpressure: output stalled for three cycles while a 4-beat stream is offered.
        do_reset();
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 16; cyc++) begin
                logic accept;
                data_out_0_ready = (cyc >= 3);
                if (idx < 4) drive(bp_d[idx], bp_b[idx], 1'b1);
                else         drive(16'h0000, 16'h0000, 1'b0);
                if (cyc == 1) check("bp_ready_open", data_in_0_ready, 1'b1);
                if (cyc == 2) begin
                    check("bp_ready_low", data_in_0_ready, 1'b0);
                    check("bp_bias_ready_low", bias_ready, 1'b0);
                    check("bp_hold_data", data_out_0[0], bp_exp[0]);
                end
                accept = data_in_0_valid && data_in_0_ready;
                if (data_out_0_valid && data_out_0_ready) begin
                    got_q.push_back(data_out_0[0]);
                    last_q.push_back(data_out_0_last);
                end
                step();
                if (accept) idx++;
            end
        end
        check("bp_count", got_q.size(), 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            check($sformatf("bp_beat_%0d", k), got_q[k], bp_exp[k]);
            check($sformatf("bp_last_%0d", k), last_q[k], 1'b0);
        end
        data_out_0_ready = 1'b1;

        // Finer input precision: 5 data fraction bits, 3 bias/output fraction bits.
        do_reset();
        drive(16'h0021, 16'h0008, 1'b1);
        step();
        check("prec_pos_valid", p_data_out_0_valid, 1'b1);
        check("prec_pos", p_data_out_0[0], 16'h0010);
        drive(16'hFFBF, 16'h0000, 1'b1);
        step();
        check("prec_neg", p_data_out_0[0], 16'hFFEF);
        drive(16'h0000, 16'h0000, 1'b0);
        step();
        check("prec_drain", p_data_out_0_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
